// File: rtl/rtc_pkg.sv
// rtc_pkg: shared types, register map and helpers for the RTC alarm controller
package rtc_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        FIRED  = 2'd2,
        SNOOZE = 2'd3
    } alarm_state_t;
    typedef struct packed {
        logic [3:0] m_h;
        logic [3:0] m_l;
        logic [3:0] s_h;
        logic [3:0] s_l;
    } bcd_time_t;
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_ALARM  = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_SNOOZE = 2'd3;
    localparam int CTRL_EN  = 0;
    localparam int CTRL_REP = 1;
    localparam int CTRL_IRQ = 2;
    function automatic logic bcd_valid(bcd_time_t t);
        return t.m_h <= 4'd5 && t.m_l <= 4'd9 && t.s_h <= 4'd5 && t.s_l <= 4'd9;
    endfunction
    function automatic logic [31:0] lane_mask(logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction
endpackage

// File: rtl/rtc_alarm_ctrl_if.sv
// rtc_alarm_ctrl_if: zero-wait-state CPU memory bus between the CPU and the alarm controller
interface rtc_alarm_ctrl_if;
    logic [31:0] address_in;
    logic        sel_in;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic        ready_out;
    modport master (
        output address_in, sel_in, write_mask_in, write_value_in,
        input  read_value_out, ready_out
    );
    modport slave (
        input  address_in, sel_in, write_mask_in, write_value_in,
        output read_value_out, ready_out
    );
endinterface

// File: rtl/rtc_snooze_timer.sv
// rtc_snooze_timer: loadable seconds countdown that pulses expired on the tick that reaches zero
module rtc_snooze_timer #(
    parameter int SNOOZE_W = 8
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                clear,
    input  logic                load,
    input  logic [SNOOZE_W-1:0] load_val,
    input  logic                run,
    input  logic                tick,
    output logic [SNOOZE_W-1:0] cnt,
    output logic                expired
);
    logic [SNOOZE_W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clear ? '0 :
                load ? load_val :
                (run && tick && cnt_q != '0) ? cnt_q - SNOOZE_W'(1) : cnt_q;
    end
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign cnt     = cnt_q;
    assign expired = run && tick && cnt_q == SNOOZE_W'(1);
endmodule

// File: rtl/rtc_alarm_ctrl.sv
// rtc_alarm_ctrl: memory-mapped alarm scheduler comparing RTC BCD mm:ss against a programmed alarm
module rtc_alarm_ctrl
    import rtc_pkg::*;
#(
    parameter int SNOOZE_W = 8
) (
    input  logic                 clk_in,
    input  logic                 reset,
    rtc_alarm_ctrl_if.slave      bus,
    input  logic [15:0]          time_in,
    input  logic                 tick_in,
    output logic                 irq_out
);
    logic [2:0]          ctrl_q, ctrl_d;
    bcd_time_t           alarm_q, alarm_d;
    logic                pending_q, pending_d;
    logic [7:0]          fire_cnt_q, fire_cnt_d;
    alarm_state_t        state_q, state_d;
    logic                irq_q, irq_d;
    logic                wr, wr_ctrl, disable_w, enable_w, ack, cnt_clr, snz_wr, match;
    logic                fire, snz_load, snz_expired;
    logic [1:0]          addr;
    logic [31:0]         lanes, wdata, rd;
    logic [SNOOZE_W-1:0] snz_cnt;
    logic                unused_ok;
    assign wr        = bus.sel_in && |bus.write_mask_in;
    assign addr      = bus.address_in[3:2];
    assign lanes     = lane_mask(bus.write_mask_in);
    assign wdata     = bus.write_value_in & lanes;
    assign wr_ctrl   = wr && addr == REG_CTRL && bus.write_mask_in[0];
    assign disable_w = wr_ctrl && !wdata[CTRL_EN];
    assign enable_w  = wr_ctrl && wdata[CTRL_EN];
    assign ack       = wr && addr == REG_STATUS && bus.write_mask_in[0] && wdata[0];
    assign cnt_clr   = wr && addr == REG_STATUS && bus.write_mask_in[1];
    assign snz_wr    = wr && addr == REG_SNOOZE && |wdata[SNOOZE_W-1:0];
    // compares against the ALARM value held before any same-cycle write
    assign match     = tick_in && time_in == alarm_q && bcd_valid(alarm_q);
    assign snz_load  = state_q == FIRED && snz_wr && !ack && !disable_w;
    assign unused_ok = ^{bus.address_in[31:4], bus.address_in[1:0], bus.write_value_in};
    rtc_snooze_timer #(.SNOOZE_W(SNOOZE_W)) u_snooze (
        .clk_in   (clk_in),
        .reset    (reset),
        .clear    (disable_w),
        .load     (snz_load),
        .load_val (wdata[SNOOZE_W-1:0]),
        .run      (state_q == SNOOZE),
        .tick     (tick_in),
        .cnt      (snz_cnt),
        .expired  (snz_expired)
    );
    always_comb begin
        ctrl_d  = wr_ctrl ? wdata[2:0] : ctrl_q;
        alarm_d = (wr && addr == REG_ALARM) ? (alarm_q & ~lanes[15:0]) | wdata[15:0] : alarm_q;
    end
    // disabling wins over any same-cycle match, expiry or acknowledge
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        fire      = 1'b0;
        if (disable_w) begin
            state_d   = IDLE;
            pending_d = 1'b0;
        end else begin
            case (state_q)
                IDLE:   state_d = enable_w ? ARMED : IDLE;
                ARMED:  fire = match;
                FIRED: begin
                    if (ack) begin
                        state_d   = ctrl_q[CTRL_REP] ? ARMED : IDLE;
                        pending_d = 1'b0;
                    end else if (snz_wr) begin
                        state_d   = SNOOZE;
                        pending_d = 1'b0;
                    end
                end
                SNOOZE: fire = snz_expired;
            endcase
            if (fire) begin
                state_d   = FIRED;
                pending_d = 1'b1;
            end
        end
        fire_cnt_d = cnt_clr ? 8'd0 : (fire && fire_cnt_q != 8'hFF) ? fire_cnt_q + 8'd1 : fire_cnt_q;
        irq_d      = pending_d && ctrl_d[CTRL_IRQ];
    end
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            ctrl_q     <= '0;
            alarm_q    <= '0;
            pending_q  <= 1'b0;
            fire_cnt_q <= '0;
            state_q    <= IDLE;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            alarm_q    <= alarm_d;
            pending_q  <= pending_d;
            fire_cnt_q <= fire_cnt_d;
            state_q    <= state_d;
            irq_q      <= irq_d;
        end
    end
    always_comb begin
        rd = addr == REG_CTRL   ? {29'd0, ctrl_q} :
             addr == REG_ALARM  ? {16'd0, alarm_q} :
             addr == REG_STATUS ? {16'd0, fire_cnt_q, 5'd0, state_q, pending_q} :
                                  32'(snz_cnt);
    end
    assign bus.read_value_out = bus.sel_in ? rd : 32'd0;
    assign bus.ready_out      = bus.sel_in;
    assign irq_out            = irq_q;
endmodule

// File: tb/tb_rtc_alarm_ctrl.sv
// tb_rtc_alarm_ctrl: directed plus randomized checks of the alarm controller against a register-level model
module tb_rtc_alarm_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] time_v = '0;
    logic        tick = 1'b0;
    logic        irq;
    int          n_tests = 0;
    int          n_fail = 0;
    int          m_ctrl, m_alarm, m_pend, m_fire, m_st, m_snz;
    rtc_alarm_ctrl_if bus();
    rtc_alarm_ctrl #(.SNOOZE_W(8)) dut (
        .clk_in  (clk),
        .reset   (rst),
        .bus     (bus),
        .time_in (time_v),
        .tick_in (tick),
        .irq_out (irq)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int bcd(input int mm, input int ss);
        return ((mm / 10) << 12) | ((mm % 10) << 8) | ((ss / 10) << 4) | (ss % 10);
    endfunction
    function automatic bit bcd_ok(input int t);
        return ((t >> 12) & 15) < 6 && ((t >> 8) & 15) < 10 && ((t >> 4) & 15) < 6 && (t & 15) < 10;
    endfunction
    function automatic int exp_rd(input int addr);
        return addr == 0 ? m_ctrl : addr == 1 ? m_alarm :
               addr == 2 ? (m_fire << 8) | (m_st << 1) | m_pend : m_snz;
    endfunction
    task automatic model_reset();
        m_ctrl = 0; m_alarm = 0; m_pend = 0; m_fire = 0; m_st = 0; m_snz = 0;
    endtask
    // states: 0 idle, 1 armed, 2 fired, 3 snoozing
    task automatic model_step(input bit sel, input int addr, input int mask, input int data, input bit tk, input int tm);
        bit wr, match, fire_now, en_wr;
        int m, d, snz;
        wr = sel && mask != 0;
        m = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        d = data & m;
        match = tk && tm == m_alarm && bcd_ok(m_alarm);
        en_wr = wr && addr == 0 && mask[0];
        snz = (wr && addr == 3) ? d & 'hFF : 0;
        fire_now = 0;
        if (en_wr && !d[0]) begin
            m_st = 0; m_pend = 0; m_snz = 0;
        end else if (m_st == 0) begin
            if (en_wr) m_st = 1;
        end else if (m_st == 1) begin
            fire_now = match;
        end else if (m_st == 2) begin
            if (wr && addr == 2 && mask[0] && d[0]) begin
                m_st = m_ctrl[1] ? 1 : 0; m_pend = 0;
            end else if (snz != 0) begin
                m_st = 3; m_snz = snz; m_pend = 0;
            end
        end else if (tk) begin
            m_snz--;
            fire_now = m_snz == 0;
        end
        if (fire_now) begin
            m_st = 2; m_pend = 1;
        end
        if (wr && addr == 2 && mask[1]) m_fire = 0;
        else if (fire_now && m_fire < 255) m_fire++;
        if (en_wr) m_ctrl = d & 7;
        if (wr && addr == 1) m_alarm = ((m_alarm & ~m) | d) & 'hFFFF;
    endtask
    task automatic step(input bit sel, input int addr, input int mask, input int data, input bit tk, input int tm);
        bus.sel_in = sel;
        bus.address_in = addr << 2;
        bus.write_mask_in = mask[3:0];
        bus.write_value_in = data;
        tick = tk;
        time_v = tm[15:0];
        @(posedge clk);
        #1;
        bus.sel_in = 1'b0;
        bus.write_mask_in = '0;
        tick = 1'b0;
        model_step(sel, addr, mask, data, tk, tm);
        chk("irq", {31'd0, irq}, m_pend != 0 && m_ctrl[2]);
    endtask
    task automatic wr(input int addr, input int mask, input int data);
        step(1, addr, mask, data, 0, 0);
    endtask
    task automatic tk(input int tm);
        step(0, 0, 0, 0, 1, tm);
    endtask
    task automatic rd_exp(input string tag, input int addr, input int exp);
        bus.sel_in = 1'b1;
        bus.address_in = addr << 2;
        bus.write_mask_in = '0;
        #1;
        chk(tag, bus.read_value_out, exp);
        bus.sel_in = 1'b0;
    endtask
    task automatic rd(input string tag, input int addr);
        rd_exp(tag, addr, exp_rd(addr));
    endtask
    initial begin
        bus.sel_in = 1'b0;
        bus.address_in = '0;
        bus.write_mask_in = '0;
        bus.write_value_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_irq", {31'd0, irq}, 0);
        rst = 1'b0;
        for (int a = 0; a < 4; a++) rd_exp("reset_reg", a, 0);
        wr(1, 'hF, 'h0105);
        wr(0, 'hF, 5);
        tk('h0104);
        tk('h0105);
        chk("basic_irq", {31'd0, irq}, 1);
        rd_exp("basic_status", 2, 'h0105);
        wr(2, 1, 1);
        rd_exp("ack_status", 2, 'h0100);
        wr(2, 2, 0);
        wr(0, 'hF, 7);
        for (int i = 0; i < 256; i++) begin
            tk('h0105);
            wr(2, 1, 1);
            rd("rep_status", 2);
        end
        rd_exp("sat_status", 2, 'hFF02);
        tk('h0105);
        wr(2, 2, 0);
        rd_exp("fired_clr", 2, 'h0005);
        wr(3, 1, 0);
        rd_exp("snz0_ignored", 2, 'h0005);
        wr(3, 1, 3);
        rd_exp("snz_state", 2, 'h0006);
        rd_exp("snz_cnt", 3, 3);
        tk('h0000);
        wr(2, 1, 1);
        rd_exp("snz_ack_noeffect", 2, 'h0006);
        tk('h0001);
        rd_exp("snz_tick2", 2, 'h0006);
        tk('h0002);
        rd_exp("snz_expire", 2, 'h0105);
        chk("snz_irq", {31'd0, irq}, 1);
        wr(2, 1, 1);
        step(1, 0, 1, 0, 1, 'h0105);
        rd_exp("prio_disable", 2, 'h0100);
        wr(0, 'hF, 5);
        step(1, 1, 'hF, 'h0200, 1, 'h0105);
        rd_exp("prio_old_alarm", 2, 'h0205);
        rd_exp("prio_new_alarm", 1, 'h0200);
        wr(2, 1, 1);
        wr(1, 'hF, 'h0100);
        wr(1, 1, 'hFFFFFF42);
        rd_exp("lane_write", 1, 'h0142);
        bus.sel_in = 1'b0;
        bus.address_in = 32'h4;
        #1;
        chk("unsel_read", bus.read_value_out, 0);
        chk("unsel_ready", {31'd0, bus.ready_out}, 0);
        wr(1, 'hF, 'h00AA);
        wr(0, 'hF, 5);
        for (int mm = 0; mm < 60; mm++)
            for (int ss = 0; ss < 60; ss++) tk(bcd(mm, ss));
        tk('h00AA);
        chk("nonbcd_irq", {31'd0, irq}, 0);
        rd("nonbcd_status", 2);
        wr(1, 'hF, 'h0105);
        tk('h0105);
        chk("pre_reset_irq", {31'd0, irq}, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_irq", {31'd0, irq}, 0);
        model_reset();
        #1;
        rst = 1'b0;
        for (int a = 0; a < 4; a++) rd_exp("post_reset_reg", a, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 600; i++) begin
            int k, mask, data;
            k = $urandom_range(0, 9);
            mask = $urandom_range(0, 15);
            if (k <= 3) tk($urandom_range(0, 2) != 0 ? m_alarm : ($urandom_range(0, 9) == 0 ? $urandom_range(0, 'hFFFF) : bcd($urandom_range(0, 59), $urandom_range(0, 59))));
            else if (k == 4) wr(0, mask, ($urandom_range(0, 4) != 0) | ($urandom_range(0, 3) << 1));
            else if (k == 5) wr(1, mask, $urandom_range(0, 7) == 0 ? $urandom() : bcd($urandom_range(0, 2), $urandom_range(0, 2)));
            else if (k == 6) wr(2, mask, $urandom());
            else if (k == 7) wr(3, mask, $urandom_range(0, 4));
            else if (k == 8) step(1, 0, mask, 1 | ($urandom_range(0, 3) << 1), 1, m_alarm);
            else step(0, 0, 0, 0, 0, 0);
            data = $urandom_range(0, 3);
            rd("rand_read", data);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
